// File: rtl/debounced_pio_pkg.sv
// Shared register map and edge-mode encoding for the debounced input PIO.
// Pure declarations; no latency or flow control of its own.
package debounced_pio_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_MODE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_e;

    function automatic logic edge_hit(edge_mode_e mode, logic rose, logic fell);
        return (rose && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
               (fell && (mode == EDGE_FALL || mode == EDGE_BOTH));
    endfunction

endpackage

// File: rtl/debounced_pio_if.sv
// Avalon-MM slave bus for the debounced PIO; read data valid one edge after
// the read strobe, no waitrequest so the slave never backpressures.
interface debounced_pio_if;

    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/debounced_pio_debounce_channel.sv
// One input channel: two-flop synchroniser plus stable-count debouncer.
// Level changes DEBOUNCE_CYCLES edges after s2 moves; rose/fell pulse the cycle before.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level,
    output logic rose,
    output logic fell
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= RESET_LEVEL;
            s2_q    <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where s2 agrees with the accepted level restarts the count.
    always_comb begin
        accept  = 1'b0;
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                accept  = 1'b1;
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign rose  = accept &  s2_q;
    assign fell  = accept & ~s2_q;

endmodule

// File: rtl/debounced_pio.sv
// Debounced Avalon-MM input PIO with W1C edge capture and masked level irq.
// Read latency 1, writes take effect on the strobe edge, irq registered; no backpressure.
module debounced_pio
    import debounced_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [WIDTH-1:0]  in_export,
    debounced_pio_if.slave    avs,
    output logic              irq
);

    logic [WIDTH-1:0] level, rose, fell, hit;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d, clr;
    edge_mode_e       mode_q, mode_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             unused_wdata;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .clk_i (clk_clk),
            .rst_i (reset_reset),
            .pin_i (in_export[gi]),
            .level (level[gi]),
            .rose  (rose[gi]),
            .fell  (fell[gi])
        );
        assign hit[gi] = edge_hit(mode_q, rose[gi], fell[gi]);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mask_q  <= '0;
            cap_q   <= '0;
            mode_q  <= EDGE_RISE;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        clr    = '0;
        if (avs.avs_write) begin
            case (avs.avs_address)
                REG_MASK: mask_d = avs.avs_writedata[WIDTH-1:0];
                REG_EDGE: clr    = avs.avs_writedata[WIDTH-1:0];
                REG_MODE: mode_d = edge_mode_e'(avs.avs_writedata[1:0]);
                default:  ;
            endcase
        end
        // A new event outranks a same-cycle clear so it is never lost.
        cap_d = (cap_q & ~clr) | hit;
        irq_d = |(cap_q & mask_q);

        rdata_d = rdata_q;
        if (avs.avs_read) begin
            rdata_d = '0;
            case (avs.avs_address)
                REG_DATA: rdata_d[WIDTH-1:0] = level;
                REG_MASK: rdata_d[WIDTH-1:0] = mask_q;
                REG_EDGE: rdata_d[WIDTH-1:0] = cap_q;
                REG_MODE: rdata_d[1:0]       = mode_q;
                default:  ;
            endcase
        end
    end

    assign unused_wdata     = ^avs.avs_writedata;
    assign avs.avs_readdata = rdata_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_debounced_pio.sv
// Directed bench for debounced_pio with WIDTH=4, DEBOUNCE_CYCLES=8, RESET_LEVEL=1.
module tb_debounced_pio;
    import debounced_pio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pins;
    logic       irq;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    debounced_pio_if bus ();

    debounced_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8),
        .RESET_LEVEL     (1'b1)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .in_export   (pins),
        .avs         (bus),
        .irq         (irq)
    );

    typedef struct {
        logic        do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        tick();
        bus.avs_read    = 1'b0;
        data            = bus.avs_readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;

        vecs[0] = '{1'b0, REG_DATA, 32'h0,        32'hF};
        vecs[1] = '{1'b0, REG_MASK, 32'h0,        32'h0};
        vecs[2] = '{1'b0, REG_EDGE, 32'h0,        32'h0};
        vecs[3] = '{1'b0, REG_MODE, 32'h0,        32'h0};
        vecs[4] = '{1'b1, REG_MASK, 32'hFFFFFFFF, 32'hF};
        vecs[5] = '{1'b1, REG_MODE, 32'hFFFFFFFF, 32'h3};
        vecs[6] = '{1'b1, REG_DATA, 32'h0,        32'hF};
        vecs[7] = '{1'b1, REG_EDGE, 32'hF,        32'h0};
        vecs[8] = '{1'b1, REG_MASK, 32'h0,        32'h0};
        vecs[9] = '{1'b1, REG_MODE, 32'h1,        32'h1};

        rst               = 1'b1;
        pins              = 4'hF;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_readdata", bus.avs_readdata, 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
        end

        // Falling edge on channel 0, mode FALL, mask bit 0: exact timing.
        wr(REG_MASK, 32'h1);
        bus.avs_address = REG_DATA;
        bus.avs_read    = 1'b1;
        pins[0]         = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("fall_data_e%0d", k), bus.avs_readdata, (k >= 10) ? 32'hE : 32'hF);
            check($sformatf("fall_irq_e%0d", k), {31'b0, irq}, (k >= 10) ? 32'h1 : 32'h0);
        end
        bus.avs_read = 1'b0;
        rd(REG_EDGE, d);
        check("fall_capture", d, 32'h1);

        // Clear, then a clear coinciding with a new falling event.
        wr(REG_EDGE, 32'h1);
        check("clr_irq_same", {31'b0, irq}, 32'h1);
        tick();
        check("clr_irq_next", {31'b0, irq}, 32'h0);
        pins[0] = 1'b1;
        repeat (12) tick();
        rd(REG_EDGE, d);
        check("rise_ignored_in_fall_mode", d, 32'h0);
        pins[0] = 1'b0;
        repeat (9) tick();
        bus.avs_address   = REG_EDGE;
        bus.avs_writedata = 32'h1;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write = 1'b0;
        tick();
        check("w1c_race_irq", {31'b0, irq}, 32'h1);
        rd(REG_EDGE, d);
        check("w1c_race_capture", d, 32'h1);
        wr(REG_EDGE, 32'h1);
        tick();
        check("w1c_late_irq", {31'b0, irq}, 32'h0);
        rd(REG_EDGE, d);
        check("w1c_late_capture", d, 32'h0);
        pins[0] = 1'b1;
        repeat (12) tick();

        // Bounce on channel 2: 7 low, 1 high, then stable low.
        wr(REG_MODE, 32'h2);
        bus.avs_address = REG_DATA;
        bus.avs_read    = 1'b1;
        for (int j = 0; j < 28; j++) begin
            pins[2] = (j == 7);
            tick();
            check($sformatf("bounce_data_e%0d", j), bus.avs_readdata, (j >= 18) ? 32'hB : 32'hF);
        end
        bus.avs_read = 1'b0;
        rd(REG_EDGE, d);
        check("bounce_capture", d, 32'h4);

        // BOTH mode then NONE mode on channel 1.
        wr(REG_EDGE, 32'hF);
        pins[1] = 1'b0;
        repeat (20) tick();
        rd(REG_EDGE, d);
        check("both_fall_capture", d, 32'h2);
        rd(REG_DATA, d);
        check("both_fall_data", d, 32'h9);
        wr(REG_EDGE, 32'h2);
        pins[1] = 1'b1;
        repeat (20) tick();
        rd(REG_EDGE, d);
        check("both_rise_capture", d, 32'h2);
        wr(REG_EDGE, 32'h2);
        wr(REG_MODE, 32'h3);
        pins[1] = 1'b0;
        repeat (20) tick();
        rd(REG_EDGE, d);
        check("none_fall_capture", d, 32'h0);
        rd(REG_DATA, d);
        check("none_fall_data", d, 32'h9);
        pins[1] = 1'b1;
        repeat (20) tick();
        rd(REG_EDGE, d);
        check("none_rise_capture", d, 32'h0);

        // Reset at edge 5 of a channel-3 debounce discards the count.
        pins = 4'hF;
        repeat (12) tick();
        bus.avs_address = REG_DATA;
        bus.avs_read    = 1'b1;
        pins[3]         = 1'b0;
        for (int j = 0; j < 21; j++) begin
            rst = (j == 5);
            tick();
            check($sformatf("rst_data_e%0d", j), bus.avs_readdata,
                  (j == 5) ? 32'h0 : ((j >= 16) ? 32'h7 : 32'hF));
        end
        rst          = 1'b0;
        bus.avs_read = 1'b0;
        rd(REG_MODE, d);
        check("rst_mode", d, 32'h0);
        rd(REG_MASK, d);
        check("rst_mask", d, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
